// File: rtl/lsu_trigger_pipe.sv
// -----------------------------------------------------------------------------
// lsu_trigger_pipe
//
// Carries the per-trigger match vector from DC3 through DC4 into DC5, resolves
// trigger chaining and the halt/exception action on the DC4 contents, and
// presents the fired-trigger result at DC5. Also keeps sticky per-trigger hit
// status and a saturating count of DC5 fire events.
//
// Ports
//   clk                    in   1  core clock
//   rst_l                  in   1  asynchronous active-low reset
//   lsu_trigger_match_dc3  in   4  per-trigger raw match (already qualified)
//   lsu_freeze_dc3         in   1  pipeline freeze, stage registers hold
//   lsu_flush_dc4          in   1  kill the instruction in DC4
//   lsu_flush_dc5          in   1  kill the instruction in DC5
//   trigger_chain          in   2  bit0: 0 chains to 1, bit1: 2 chains to 3
//   trigger_action         in   4  per trigger: 1 = debug halt, 0 = exception
//   dec_tlu_hit_clr        in   4  per-trigger clear of sticky hit
//   lsu_trigger_match_dc5  out  4  final fired-trigger vector
//   lsu_trigger_halt_dc5   out  1  a fired trigger requests halt
//   lsu_trigger_exc_dc5    out  1  a fired trigger requests exception only
//   lsu_trigger_hit        out  4  sticky hit status
//   lsu_trigger_fire_cnt   out  8  saturating count of DC5 fire events
// -----------------------------------------------------------------------------
module lsu_trigger_pipe (
   input  logic       clk,
   input  logic       rst_l,
   input  logic [3:0] lsu_trigger_match_dc3,
   input  logic       lsu_freeze_dc3,
   input  logic       lsu_flush_dc4,
   input  logic       lsu_flush_dc5,
   input  logic [1:0] trigger_chain,
   input  logic [3:0] trigger_action,
   input  logic [3:0] dec_tlu_hit_clr,
   output logic [3:0] lsu_trigger_match_dc5,
   output logic       lsu_trigger_halt_dc5,
   output logic       lsu_trigger_exc_dc5,
   output logic [3:0] lsu_trigger_hit,
   output logic [7:0] lsu_trigger_fire_cnt
);

   localparam logic [7:0] CNT_MAX = 8'hFF;

   logic [3:0] m_dc4_q, m_dc4_d;
   logic [3:0] m_dc5_q, m_dc5_d;
   logic       halt_dc5_q, halt_dc5_d;
   logic       exc_dc5_q, exc_dc5_d;
   logic [3:0] hit_q, hit_d;
   logic [7:0] cnt_q, cnt_d;

   logic [3:0] chain_res;
   logic [3:0] res_dc4;
   logic       halt_dc4;
   logic       exc_dc4;
   logic [3:0] fire_dc5;
   logic       any_fire_dc5;

   // A chained pair only fires when both members match; each member then
   // reports the fire so the TLU sees the whole pair.
   function automatic logic [1:0] resolve_pair(input logic [1:0] m,
                                               input logic       chained);
      logic both;
      both = m[0] & m[1];
      if (chained) resolve_pair = {both, both};
      else         resolve_pair = m;
   endfunction

   // Chain and action resolution on DC4 contents, using the configuration
   // as it stands while the instruction sits in DC4.
   always_comb begin
      chain_res      = '0;
      chain_res[1:0] = resolve_pair(m_dc4_q[1:0], trigger_chain[0]);
      chain_res[3:2] = resolve_pair(m_dc4_q[3:2], trigger_chain[1]);

      res_dc4  = lsu_flush_dc4 ? 4'b0000 : chain_res;
      halt_dc4 = |(res_dc4 & trigger_action);
      exc_dc4  = (|(res_dc4 & ~trigger_action)) & ~halt_dc4;
   end

   // Stage next-state. Freeze holds both stages; a flush of a stage still
   // clears it while frozen. An unfrozen DC4 flush already zeroed res_dc4.
   always_comb begin
      m_dc4_d    = m_dc4_q;
      m_dc5_d    = m_dc5_q;
      halt_dc5_d = halt_dc5_q;
      exc_dc5_d  = exc_dc5_q;

      if (lsu_freeze_dc3) begin
         if (lsu_flush_dc4) m_dc4_d = 4'b0000;
      end else begin
         m_dc4_d    = lsu_trigger_match_dc3;
         m_dc5_d    = res_dc4;
         halt_dc5_d = halt_dc4;
         exc_dc5_d  = exc_dc4;
      end

      if (lsu_flush_dc5) begin
         m_dc5_d    = 4'b0000;
         halt_dc5_d = 1'b0;
         exc_dc5_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         m_dc4_q    <= 4'b0000;
         m_dc5_q    <= 4'b0000;
         halt_dc5_q <= 1'b0;
         exc_dc5_q  <= 1'b0;
      end else begin
         m_dc4_q    <= m_dc4_d;
         m_dc5_q    <= m_dc5_d;
         halt_dc5_q <= halt_dc5_d;
         exc_dc5_q  <= exc_dc5_d;
      end
   end

   // DC5 flush kills the outputs in the same cycle it is asserted.
   assign fire_dc5     = lsu_flush_dc5 ? 4'b0000 : m_dc5_q;
   assign any_fire_dc5 = |fire_dc5;

   assign lsu_trigger_match_dc5 = fire_dc5;
   assign lsu_trigger_halt_dc5  = halt_dc5_q & ~lsu_flush_dc5;
   assign lsu_trigger_exc_dc5   = exc_dc5_q & ~lsu_flush_dc5;

   // Sticky hit: a new fire beats a clear arriving in the same cycle.
   always_comb begin
      hit_d = (hit_q & ~dec_tlu_hit_clr) | fire_dc5;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (any_fire_dc5 && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         hit_q <= 4'b0000;
         cnt_q <= 8'h00;
      end else begin
         hit_q <= hit_d;
         cnt_q <= cnt_d;
      end
   end

   assign lsu_trigger_hit      = hit_q;
   assign lsu_trigger_fire_cnt = cnt_q;

endmodule

// File: tb/tb_lsu_trigger_pipe.sv
module tb_lsu_trigger_pipe;

   logic       clk;
   logic       rst_l;
   logic [3:0] match_dc3;
   logic       freeze;
   logic       flush_dc4;
   logic       flush_dc5;
   logic [1:0] chain;
   logic [3:0] action;
   logic [3:0] hit_clr;
   logic [3:0] match_dc5;
   logic       halt_dc5;
   logic       exc_dc5;
   logic [3:0] hit;
   logic [7:0] cnt;

   int tests_run = 0;
   int tests_failed = 0;

   lsu_trigger_pipe dut (
      .clk                   (clk),
      .rst_l                 (rst_l),
      .lsu_trigger_match_dc3 (match_dc3),
      .lsu_freeze_dc3        (freeze),
      .lsu_flush_dc4         (flush_dc4),
      .lsu_flush_dc5         (flush_dc5),
      .trigger_chain         (chain),
      .trigger_action        (action),
      .dec_tlu_hit_clr       (hit_clr),
      .lsu_trigger_match_dc5 (match_dc5),
      .lsu_trigger_halt_dc5  (halt_dc5),
      .lsu_trigger_exc_dc5   (exc_dc5),
      .lsu_trigger_hit       (hit),
      .lsu_trigger_fire_cnt  (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Start a new cycle: inputs written after this belong to that cycle.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_l = 1'b1; match_dc3 = 4'b0; freeze = 1'b0; flush_dc4 = 1'b0;
      flush_dc5 = 1'b0; chain = 2'b00; action = 4'b0000; hit_clr = 4'b0000;
      #1 rst_l = 1'b0;
      #1;
      chk("rst_match", {4'b0, match_dc5}, 8'h00);
      chk("rst_halt", {7'b0, halt_dc5}, 8'h00);
      chk("rst_exc", {7'b0, exc_dc5}, 8'h00);
      chk("rst_hit", {4'b0, hit}, 8'h00);
      chk("rst_cnt", cnt, 8'h00);
      cyc(); cyc();
      rst_l = 1'b1;
      cyc();

      // Single unchained match, exception action
      match_dc3 = 4'b0100;
      cyc(); match_dc3 = 4'b0000; #1;
      chk("single_c1", {4'b0, match_dc5}, 8'h00);
      cyc(); #1;
      chk("single_c2_match", {4'b0, match_dc5}, 8'h04);
      chk("single_c2_exc", {7'b0, exc_dc5}, 8'h01);
      chk("single_c2_halt", {7'b0, halt_dc5}, 8'h00);
      cyc(); #1;
      chk("single_c3_match", {4'b0, match_dc5}, 8'h00);
      chk("single_c3_hit", {4'b0, hit}, 8'h04);
      chk("single_c3_cnt", cnt, 8'h01);

      // Chain pair 0/1, trigger 1 halts (halt beats trigger 0 exception)
      cyc(); chain = 2'b01; action = 4'b0010; match_dc3 = 4'b0001;
      cyc(); match_dc3 = 4'b0011;
      cyc(); match_dc3 = 4'b0000; #1;
      chk("chain01_half", {4'b0, match_dc5}, 8'h00);
      cyc(); #1;
      chk("chain01_match", {4'b0, match_dc5}, 8'h03);
      chk("chain01_halt", {7'b0, halt_dc5}, 8'h01);
      chk("chain01_exc", {7'b0, exc_dc5}, 8'h00);
      cyc(); chain = 2'b00; action = 4'b0000; #1;
      chk("chain01_after", {4'b0, match_dc5}, 8'h00);
      chk("chain01_cnt", cnt, 8'h02);
      chk("chain01_hit", {4'b0, hit}, 8'h07);

      // Chain pair 2/3
      cyc(); chain = 2'b10; match_dc3 = 4'b1000;
      cyc(); match_dc3 = 4'b1100;
      cyc(); match_dc3 = 4'b0000; #1;
      chk("chain23_half", {4'b0, match_dc5}, 8'h00);
      cyc(); #1;
      chk("chain23_match", {4'b0, match_dc5}, 8'h0C);
      chk("chain23_exc", {7'b0, exc_dc5}, 8'h01);
      chk("chain23_halt", {7'b0, halt_dc5}, 8'h00);
      cyc(); chain = 2'b00; #1;
      chk("chain23_cnt", cnt, 8'h03);
      chk("chain23_hit", {4'b0, hit}, 8'h0F);
      hit_clr = 4'b1111;
      cyc(); hit_clr = 4'b0000; #1;
      chk("clr_all", {4'b0, hit}, 8'h00);

      // Freeze for three cycles; frozen DC3 input must be ignored
      cyc(); match_dc3 = 4'b1000; action = 4'b1000;
      cyc(); match_dc3 = 4'b0000; freeze = 1'b1;
      cyc(); match_dc3 = 4'b0001; #1;
      chk("frz_c2", {4'b0, match_dc5}, 8'h00);
      cyc(); match_dc3 = 4'b0000; #1;
      chk("frz_c3", {4'b0, match_dc5}, 8'h00);
      cyc(); freeze = 1'b0; #1;
      chk("frz_c4", {4'b0, match_dc5}, 8'h00);
      cyc(); action = 4'b0000; #1;
      chk("frz_c5_match", {4'b0, match_dc5}, 8'h08);
      chk("frz_c5_halt_cfg_late", {7'b0, halt_dc5}, 8'h01);
      cyc(); #1;
      chk("frz_c6_match", {4'b0, match_dc5}, 8'h00);
      chk("frz_c6_cnt", cnt, 8'h04);
      chk("frz_c6_hit", {4'b0, hit}, 8'h08);

      // Flush in DC4
      cyc(); match_dc3 = 4'b0010;
      cyc(); match_dc3 = 4'b0000; flush_dc4 = 1'b1;
      cyc(); flush_dc4 = 1'b0; #1;
      chk("fl4_c2", {4'b0, match_dc5}, 8'h00);
      cyc(); #1;
      chk("fl4_c3", {4'b0, match_dc5}, 8'h00);
      chk("fl4_cnt", cnt, 8'h04);

      // Flush in DC5: gated same cycle, register cleared after
      cyc(); match_dc3 = 4'b0100;
      cyc(); match_dc3 = 4'b0000;
      cyc(); flush_dc5 = 1'b1; #1;
      chk("fl5_match", {4'b0, match_dc5}, 8'h00);
      chk("fl5_exc", {7'b0, exc_dc5}, 8'h00);
      chk("fl5_halt", {7'b0, halt_dc5}, 8'h00);
      cyc(); flush_dc5 = 1'b0; #1;
      chk("fl5_after", {4'b0, match_dc5}, 8'h00);
      chk("fl5_cnt", cnt, 8'h04);
      chk("fl5_hit", {4'b0, hit}, 8'h08);
      hit_clr = 4'b1111;
      cyc(); hit_clr = 4'b0000;

      // Sticky collision, back-to-back trigger 1 fires
      cyc(); match_dc3 = 4'b0010;
      cyc(); match_dc3 = 4'b0010;
      cyc(); match_dc3 = 4'b0000; #1;
      chk("b2b_first", {4'b0, match_dc5}, 8'h02);
      cyc(); hit_clr = 4'b0010; #1;
      chk("b2b_second", {4'b0, match_dc5}, 8'h02);
      chk("b2b_hit_pre", {4'b0, hit}, 8'h02);
      cyc(); #1;
      chk("collide_hit", {4'b0, hit}, 8'h02);
      chk("collide_cnt", cnt, 8'h06);
      cyc(); hit_clr = 4'b0000; #1;
      chk("clr_alone_hit", {4'b0, hit}, 8'h00);

      // Counter saturation, then async reset mid-stream
      match_dc3 = 4'b0001;
      for (int i = 0; i < 262; i++) cyc();
      chk("sat_cnt", cnt, 8'hFF);
      chk("sat_match", {4'b0, match_dc5}, 8'h01);
      chk("sat_hit", {4'b0, hit}, 8'h01);
      cyc();
      chk("sat_hold", cnt, 8'hFF);
      #2 rst_l = 1'b0;
      #1;
      chk("arst_match", {4'b0, match_dc5}, 8'h00);
      chk("arst_exc", {7'b0, exc_dc5}, 8'h00);
      chk("arst_cnt", cnt, 8'h00);
      chk("arst_hit", {4'b0, hit}, 8'h00);
      cyc(); match_dc3 = 4'b0000;
      cyc(); rst_l = 1'b1;
      cyc(); #1;
      chk("post_rst_c1", {4'b0, match_dc5}, 8'h00);
      cyc(); #1;
      chk("post_rst_c2", {4'b0, match_dc5}, 8'h00);
      chk("post_rst_cnt", cnt, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
